pkt_fifo: RTL and testbench

PKT_FIFO -- requirements
Module: pkt_fifo

---
 rtl/pkt_fifo_outreg.sv | 24 ++
 rtl/pkt_fifo.sv | 122 ++++++++++++
 tb/tb_pkt_fifo.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_fifo_outreg.sv
// Registered read stage for pkt_fifo: one extra cycle of read latency.
// Reloads every cycle from the prefetch address, so the word holds while the consumer stalls.
module pkt_fifo_outreg #(
  parameter int BW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        avail,
  input  logic [BW:0] word,
  output logic        valid,
  output logic [BW:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= avail;
      q     <= word;
    end
  end

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO: written words stay invisible to the reader until their packet's last word lands.
// A packet that would fill the whole FIFO uncommitted is dropped through its last word.
module pkt_fifo #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter bit OPT_ASYNC_READ = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wr,
  input  logic [BW-1:0]   i_data,
  input  logic            i_last,
  input  logic            i_abort,
  output logic            o_full,
  output logic            o_overflow,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BW-1:0]   o_data,
  output logic            o_last,
  output logic [LGFLEN:0] o_fill,
  output logic [LGFLEN:0] o_pkts
);

  localparam int unsigned     FLEN      = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_DIFF = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] PTR_ONE   = {{LGFLEN{1'b0}}, 1'b1};

  typedef enum logic {FILL, DROP} wstate_t;

  wstate_t         state, state_next;
  logic [LGFLEN:0] wr_addr, commit_addr, rd_addr, rd_next;
  logic [BW:0]     mem [FLEN];
  logic [BW:0]     rd_word;
  logic            accept, commit, rewind, drop_start, xfer, rd_last;

  assign o_full  = (state == FILL) && ((wr_addr - rd_addr) == FULL_DIFF);
  assign o_fill  = commit_addr - rd_addr;
  assign xfer    = o_valid && i_ready;
  assign rd_last = xfer && o_last;
  assign rd_next = xfer ? rd_addr + PTR_ONE : rd_addr;
  assign commit  = accept && i_last;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= FILL;
    else            state <= state_next;
  end

  // Abort wins over everything; the drop check only fires once the uncommitted packet owns every slot.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rewind     = 1'b0;
    drop_start = 1'b0;
    case (state)
      FILL: begin
        if (i_abort) begin
          rewind = 1'b1;
        end else if (o_full && (commit_addr == rd_addr)) begin
          state_next = DROP;
          rewind     = 1'b1;
          drop_start = 1'b1;
        end else if (i_wr && !o_full) begin
          accept = 1'b1;
        end
      end
      DROP: begin
        if (i_abort || (i_wr && i_last)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_addr     <= '0;
      commit_addr <= '0;
      rd_addr     <= '0;
      o_pkts      <= '0;
      o_overflow  <= 1'b0;
    end else begin
      if (rewind)      wr_addr <= commit_addr;
      else if (accept) wr_addr <= wr_addr + PTR_ONE;
      if (commit) commit_addr <= wr_addr + PTR_ONE;
      rd_addr    <= rd_next;
      o_overflow <= drop_start;
      case ({commit, rd_last})
        2'b10:   o_pkts <= o_pkts + PTR_ONE;
        2'b01:   o_pkts <= o_pkts - PTR_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_addr[LGFLEN-1:0]] <= {i_last, i_data};
  end

  assign {o_last, o_data} = rd_word;

  if (OPT_ASYNC_READ) begin : g_async
    assign o_valid = (commit_addr != rd_addr);
    assign rd_word = mem[rd_addr[LGFLEN-1:0]];
  end else begin : g_reg
    logic        pre_avail;
    logic [BW:0] pre_word;

    // Prefetch at the post-transfer pointer against this cycle's commit pointer,
    // so a fresh packet shows one cycle later than the combinational path.
    assign pre_avail = (commit_addr != rd_next);
    assign pre_word  = mem[rd_next[LGFLEN-1:0]];

    pkt_fifo_outreg #(.BW(BW)) u_outreg (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .avail (pre_avail),
      .word  (pre_word),
      .valid (o_valid),
      .q     (rd_word)
    );
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: combinational-read and registered-read instances share one stimulus,
// each checked against its own scoreboard of committed words.
module tb_pkt_fifo;
  localparam int BW = 8;
  localparam int LG = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr    = 1'b0;
  logic          last  = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic [BW-1:0] data  = '0;

  logic          full0, ovf0, valid0, last0, full1, ovf1, valid1, last1;
  logic [BW-1:0] q0, q1;
  logic [LG:0]   fill0, pkts0, fill1, pkts1;

  int total = 0;
  int bad   = 0;
  logic [BW:0] exp0[$];
  logic [BW:0] exp1[$];
  logic [BW:0] pend[$];

  always #5 clk = ~clk;

  pkt_fifo #(.BW(BW), .LGFLEN(LG), .OPT_ASYNC_READ(1'b1)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_data(data), .i_last(last), .i_abort(abort),
    .o_full(full0), .o_overflow(ovf0), .o_valid(valid0), .i_ready(ready), .o_data(q0),
    .o_last(last0), .o_fill(fill0), .o_pkts(pkts0)
  );

  pkt_fifo #(.BW(BW), .LGFLEN(LG), .OPT_ASYNC_READ(1'b0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_data(data), .i_last(last), .i_abort(abort),
    .o_full(full1), .o_overflow(ovf1), .o_valid(valid1), .i_ready(ready), .o_data(q1),
    .o_last(last1), .o_fill(fill1), .o_pkts(pkts1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid0 && ready) begin
      total++;
      assert (exp0.size() != 0) else begin
        bad++;
        $error("FAIL dut0_spurious: observed=0x%0h expected=none", {last0, q0});
      end
      if (exp0.size() != 0) check("dut0_word", 32'({last0, q0}), 32'(exp0.pop_front()));
    end
    if (rst_n && valid1 && ready) begin
      total++;
      assert (exp1.size() != 0) else begin
        bad++;
        $error("FAIL dut1_spurious: observed=0x%0h expected=none", {last1, q1});
      end
      if (exp1.size() != 0) check("dut1_word", 32'({last1, q1}), 32'(exp1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] d, input logic l, input bit keep);
    wr   = 1'b1;
    data = d;
    last = l;
    if (keep) begin
      pend.push_back({l, d});
      if (l) begin
        foreach (pend[i]) begin
          exp0.push_back(pend[i]);
          exp1.push_back(pend[i]);
        end
        pend.delete();
      end
    end
    tick();
    wr   = 1'b0;
    last = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    ready = 1'b1;
    while ((exp0.size() + exp1.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(exp0.size() + exp1.size()), 32'd0);
    check({tag, "_fill"}, 32'(fill0) + 32'(fill1), 32'd0);
    check({tag, "_pkts"}, 32'(pkts0) + 32'(pkts1), 32'd0);
    ready = 1'b0;
  endtask

  initial begin
    int len;
    int guard;

    tick();
    tick();
    check("rst_full",  32'(full0),  32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_fill",  32'(fill0),  32'd0);
    check("rst_pkts",  32'(pkts0),  32'd0);
    check("rst_ovf",   32'(ovf0),   32'd0);
    check("rst_valid_reg", 32'(valid1), 32'd0);
    rst_n = 1'b1;
    tick();

    // three-word packet, visibility and latency
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    check("t1_valid_precommit", 32'(valid0), 32'd0);
    send(8'h33, 1'b1, 1'b1);
    check("t1_valid", 32'(valid0), 32'd1);
    check("t1_head",  32'({last0, q0}), 32'h011);
    check("t1_pkts",  32'(pkts0), 32'd1);
    check("t1_fill",  32'(fill0), 32'd3);
    check("t1_reg_lag", 32'(valid1), 32'd0);
    tick();
    check("t1_reg_valid", 32'(valid1), 32'd1);
    check("t1_reg_head",  32'({last1, q1}), 32'h011);
    drain("t1_drain");

    // abort, with a same-cycle write that must be discarded
    send(8'hA0, 1'b0, 1'b1);
    send(8'hA1, 1'b0, 1'b1);
    wr = 1'b1; data = 8'hA2; abort = 1'b1;
    tick();
    wr = 1'b0; abort = 1'b0;
    pend.delete();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_valid", 32'(valid0), 32'd0);
      check("t2_valid_reg", 32'(valid1), 32'd0);
      check("t2_fill", 32'(fill0), 32'd0);
      tick();
    end
    ready = 1'b0;
    send(8'h55, 1'b1, 1'b1);
    drain("t2_drain");

    // oversize packet dropped through its last word
    for (int i = 0; i < 16; i++) send(8'(8'hB0 + i), 1'b0, 1'b0);
    check("t3_full", 32'(full0), 32'd1);
    check("t3_fill_hidden", 32'(fill0), 32'd0);
    check("t3_ovf_early", 32'(ovf0), 32'd0);
    tick();
    check("t3_ovf", 32'(ovf0), 32'd1);
    check("t3_ovf_reg", 32'(ovf1), 32'd1);
    check("t3_full_drop", 32'(full0), 32'd0);
    tick();
    check("t3_ovf_pulse", 32'(ovf0), 32'd0);
    send(8'hC0, 1'b0, 1'b0);
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b1, 1'b0);
    check("t3_fill_after_drop", 32'(fill0), 32'd0);
    check("t3_valid_after_drop", 32'(valid0), 32'd0);
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b1, 1'b1);
    drain("t3_drain");

    // full boundary with committed data backing up
    for (int i = 0; i < 15; i++) send(8'(i), (i == 14), 1'b1);
    check("t4_full_15", 32'(full0), 32'd0);
    check("t4_fill_15", 32'(fill0), 32'd15);
    send(8'h7F, 1'b0, 1'b1);
    check("t4_full", 32'(full0), 32'd1);
    check("t4_full_reg", 32'(full1), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t4_full_released", 32'(full0), 32'd0);
    check("t4_fill_14", 32'(fill0), 32'd14);
    send(8'h80, 1'b1, 1'b1);
    check("t4_fill_max", 32'(fill0), 32'd16);
    check("t4_full_again", 32'(full0), 32'd1);
    check("t4_pkts", 32'(pkts0), 32'd2);
    drain("t4_drain");

    // reset mid-packet with two committed packets
    send(8'h91, 1'b0, 1'b1);
    send(8'h92, 1'b1, 1'b1);
    send(8'h93, 1'b1, 1'b1);
    send(8'h94, 1'b0, 1'b1);
    tick();
    check("t5_pkts_pre", 32'(pkts0), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(valid0), 32'd0);
    check("t5_fill",  32'(fill0),  32'd0);
    check("t5_pkts",  32'(pkts0),  32'd0);
    check("t5_valid_reg", 32'(valid1), 32'd0);
    check("t5_fill_reg",  32'(fill1),  32'd0);
    check("t5_pkts_reg",  32'(pkts1),  32'd0);
    check("t5_full",  32'(full0),  32'd0);
    exp0.delete();
    exp1.delete();
    pend.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h99, 1'b1, 1'b1);
    drain("t5_drain");

    // random packet stream with random back-pressure, wrapping pointers
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      for (int w = 0; w < len; w++) begin
        guard = 0;
        while ((full0 || full1) && guard < 100) begin
          ready = 1'($urandom_range(0, 1));
          tick();
          guard++;
        end
        check("t6_full_wait", 32'(full0 || full1), 32'd0);
        ready = 1'($urandom_range(0, 1));
        send(8'($urandom), (w == len - 1), 1'b1);
      end
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
